// File: rtl/chrono_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : chrono_run_controller
//  Description : Stopwatch run/stop/lap/clear sequencer with debounced buttons,
//                gated 100 Hz tick, one-cycle counter clear and lap display hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module chrono_run_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       tick_in,
   input  logic       btn_start_stop,
   input  logic       btn_lap_reset,
   output logic       tick_out,
   output logic       count_clear,
   output logic       display_hold,
   output logic [1:0] state_out
);

   localparam logic [1:0]       IDLE     = 2'b00;
   localparam logic [1:0]       RUN      = 2'b01;
   localparam logic [1:0]       LAP      = 2'b11;
   localparam logic [1:0]       PAUSE    = 2'b10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0] btn_raw;
   logic [1:0] press;
   logic [1:0] state;
   logic [1:0] next_state;
   logic       clear_next;
   logic       hold_next;
   logic       tick_next;
   logic       start_press;
   logic       lap_press;

   assign btn_raw     = {btn_lap_reset, btn_start_stop};
   assign start_press = press[0];
   assign lap_press   = press[1];

   // Bit 0 = start/stop, bit 1 = lap/reset; identical synchronise+debounce paths.
   for (genvar i = 0; i < 2; i++) begin : g_btn
      logic             sync_a;
      logic             sync_b;
      logic             level;
      logic             press_q;
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            press_q <= 1'b0;
            cnt     <= '0;
         end else begin
            sync_a  <= btn_raw[i];
            sync_b  <= sync_a;
            press_q <= 1'b0;
            if (sync_b == level) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               level   <= ~level;
               cnt     <= '0;
               press_q <= ~level;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end

      assign press[i] = press_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= IDLE;
         count_clear  <= 1'b0;
         display_hold <= 1'b0;
         tick_out     <= 1'b0;
      end else begin
         state        <= next_state;
         count_clear  <= clear_next;
         display_hold <= hold_next;
         tick_out     <= tick_next;
      end
   end

   // Start has priority: a simultaneous lap press is simply not looked at.
   always_comb begin
      next_state = state;
      if (start_press) begin
         case (state)
            IDLE:    next_state = RUN;
            RUN:     next_state = PAUSE;
            LAP:     next_state = PAUSE;
            PAUSE:   next_state = RUN;
            default: next_state = IDLE;
         endcase
      end else if (lap_press) begin
         case (state)
            IDLE:    next_state = IDLE;
            RUN:     next_state = LAP;
            LAP:     next_state = RUN;
            PAUSE:   next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Tick gating uses the pre-transition state; a clear always wins over a tick.
   always_comb begin
      clear_next = 1'b0;
      hold_next  = 1'b0;
      tick_next  = 1'b0;
      clear_next = !start_press && lap_press && (state == IDLE || state == PAUSE);
      hold_next  = (next_state == LAP);
      tick_next  = tick_in && (state == RUN || state == LAP) && !clear_next;
   end

   assign state_out = state;

endmodule
`default_nettype wire

// File: tb/tb_chrono_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chrono_run_controller
//  Description : Scoreboard bench for chrono_run_controller (DEBOUNCE_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chrono_run_controller;

   localparam int C_DEB = 4;
   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_LAP   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       bs = 1'b0;
   logic       bl = 1'b0;
   logic       tick_out;
   logic       count_clear;
   logic       display_hold;
   logic [1:0] state_out;

   chrono_run_controller #(.DEBOUNCE_CYCLES(C_DEB), .CNT_W(3)) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .tick_in        (tick),
      .btn_start_stop (bs),
      .btn_lap_reset  (bl),
      .tick_out       (tick_out),
      .count_clear    (count_clear),
      .display_hold   (display_hold),
      .state_out      (state_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] st;
      logic       clr;
      logic       hold;
      logic       tk;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: button level accepted once the synchronised raw value has
   // disagreed with it for DEB consecutive samples; the FSM is a transition table.
   bit [1:0] hist[$];
   bit       m_deb[2];
   bit       m_press[2];
   int       m_st = S_IDLE;

   function automatic bit window_differs(int b, bit d);
      int n = hist.size();
      for (int i = 2; i <= C_DEB + 1; i++)
         if (hist[n-i][b] == d) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step(input bit r, input bit t, input bit s, input bit l);
      exp_t e;
      int   ns;
      bit   clr;
      bit   tk;
      bit   np[2];
      if (r) begin
         hist.delete();
         for (int i = 0; i < 6; i++) hist.push_back(2'b00);
         m_deb[0] = 0; m_deb[1] = 0; m_press[0] = 0; m_press[1] = 0;
         m_st = S_IDLE;
         e = '0;
      end else begin
         ns  = m_st;
         clr = 0;
         if (m_press[0]) begin
            ns = (m_st == S_IDLE || m_st == S_PAUSE) ? S_RUN : S_PAUSE;
         end else if (m_press[1]) begin
            case (m_st)
               S_IDLE:  clr = 1;
               S_RUN:   ns  = S_LAP;
               S_LAP:   ns  = S_RUN;
               default: begin ns = S_IDLE; clr = 1; end
            endcase
         end
         tk = t && (m_st == S_RUN || m_st == S_LAP) && !clr;
         for (int b = 0; b < 2; b++) begin
            np[b] = 0;
            if (window_differs(b, m_deb[b])) begin
               m_deb[b] = !m_deb[b];
               np[b]    = m_deb[b];
            end
         end
         m_press[0] = np[0];
         m_press[1] = np[1];
         hist.push_back({l, s});
         while (hist.size() > 8) void'(hist.pop_front());
         m_st   = ns;
         e.st   = 2'(ns);
         e.clr  = clr;
         e.hold = (ns == S_LAP);
         e.tk   = tk;
      end
      exp_q.push_back(e);
   endtask

   task automatic cyc(input bit r, input bit t, input bit s, input bit l);
      @(negedge clk);
      #1;
      rst = r; tick = t; bs = s; bl = l;
      model_step(r, t, s, l);
      @(posedge clk);
      #1;
   endtask

   function automatic bit rtick();
      return ($urandom_range(0, 2) == 0);
   endfunction

   task automatic press_btn(input int which, input int hold_cycles);
      for (int i = 0; i < hold_cycles; i++) cyc(0, rtick(), which[0], which[1]);
      for (int i = 0; i < 8; i++) cyc(0, rtick(), 0, 0);
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({state_out, count_clear, display_hold, tick_out} !== mon_e) begin
            errors++;
            $display("FAIL outputs t=%0t: got st=%b clr=%b hold=%b tick=%b, expected st=%b clr=%b hold=%b tick=%b",
                     $time, state_out, count_clear, display_hold, tick_out,
                     mon_e.st, mon_e.clr, mon_e.hold, mon_e.tk);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int edge_at;
      int seg;
      bit ls;
      bit ll;
      for (int i = 0; i < 6; i++) hist.push_back(2'b00);

      // Reset with buttons and tick active
      for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1);
      for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0);

      // Start: state must become RUN exactly 7 edges after the raw edge
      edge_at = -1;
      for (int i = 1; i <= 10; i++) begin
         cyc(0, rtick(), 1, 0);
         if (edge_at < 0 && state_out == 2'b01) edge_at = i;
      end
      checks++;
      if (edge_at != 7) begin
         errors++;
         $display("FAIL start_latency: state RUN seen at edge %0d, expected 7", edge_at);
      end
      for (int i = 0; i < 8; i++) cyc(0, rtick(), 0, 0);

      // Bounce on lap: must not register
      cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1); cyc(0, 1, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, rtick(), 0, 0);

      // Lap in and out, then pause and clear
      press_btn(2, 6);
      press_btn(2, 6);
      press_btn(1, 6);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
      press_btn(2, 6);

      // Simultaneous presses from RUN, then reset mid-run
      press_btn(1, 6);
      press_btn(3, 6);
      press_btn(1, 6);
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);

      // Randomised segments with bounce, ticks and occasional reset
      for (int k = 0; k < 300; k++) begin
         seg = $urandom_range(1, 12);
         ls  = $urandom_range(0, 1) == 1;
         ll  = $urandom_range(0, 1) == 1;
         for (int i = 0; i < seg; i++)
            cyc(($urandom_range(0, 299) == 0), rtick(), ls, ll);
      end
      for (int i = 0; i < 10; i++) cyc(0, rtick(), 0, 0);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
